// File: rtl/riscv_mem_pkg.sv
// Shared constants and FSM state type for the MEM-stage data-memory path.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: misalignment check, byte-enable/write-data steering,
// and load-data extraction with sign or zero extension.
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    assign byte_shifted = rdata_word >> {addr_lo, 3'b000};
    assign half_shifted = rdata_word >> {addr_lo[1], 4'b0000};

    // Reserved size codes fall through to the word path.
    always_comb begin
        misaligned  = 1'b0;
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rdata_word;
        case (funct3)
            F3_B, F3_BU: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = (funct3 == F3_B) ? {{24{byte_shifted[7]}}, byte_shifted[7:0]}
                                               : {24'b0, byte_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misaligned  = addr_lo[0];
                be          = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = (funct3 == F3_H) ? {{16{half_shifted[15]}}, half_shifted[15:0]}
                                               : {16'b0, half_shifted[15:0]};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: single-outstanding req/ack bus access with
// pipeline stall generation, timeout abort and aligned load-data return.
module dmem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IM_MEMREAD,
    input  logic              IM_MEMWRITE,
    input  logic [2:0]        IM_FUNCT3,
    input  logic [ADDR_W-1:0] IM_ADDR,
    input  logic [31:0]       IM_WDATA,
    output logic              MEM_RDY,
    output logic [31:0]       IM_RDATA,
    output logic              MISALIGNED,
    output logic              BUS_ERR,
    output logic              BUS_REQ,
    output logic              BUS_WE,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic [3:0]        BUS_BE,
    output logic [31:0]       BUS_WDATA,
    input  logic              BUS_ACK,
    input  logic [31:0]       BUS_RDATA,
    output dmem_state_t       DBG_STATE
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dmem_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [31:0]      rdata_q;

    logic        req;
    logic        is_store;
    logic        start;
    logic        timed_out;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wdata_lanes;
    logic [31:0] rdata_ext;

    assign req       = IM_MEMREAD | IM_MEMWRITE;
    assign is_store  = IM_MEMWRITE;
    assign start     = (state == IDLE) && req && !misaligned;
    assign timed_out = TIMEOUT_EN && (state == REQ) && !BUS_ACK && (cnt == CNT_LAST);
    assign DBG_STATE = state;

    // Outside IDLE the lane logic must decode the captured access, not live inputs.
    assign sel_funct3  = (state == IDLE) ? IM_FUNCT3   : funct3_q;
    assign sel_addr_lo = (state == IDLE) ? IM_ADDR[1:0] : addr_lo_q;

    load_store_align u_align (
        .funct3      (sel_funct3),
        .addr_lo     (sel_addr_lo),
        .wdata       (IM_WDATA),
        .rdata_word  (BUS_RDATA),
        .misaligned  (misaligned),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (BUS_ACK || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        MEM_RDY    = 1'b1;
        MISALIGNED = 1'b0;
        IM_RDATA   = rdata_q;
        case (state)
            IDLE: begin
                if (req && misaligned) begin
                    MISALIGNED = 1'b1;
                    IM_RDATA   = 32'b0;
                end else if (req) begin
                    MEM_RDY = 1'b0;
                end
            end
            REQ:     MEM_RDY = 1'b0;
            default: MEM_RDY = 1'b1;
        endcase
    end

    // Bus-side registers; BUS_WE doubles as the store flag while in REQ.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUS_REQ   <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= '0;
            BUS_BE    <= 4'b0;
            BUS_WDATA <= 32'b0;
            BUS_ERR   <= 1'b0;
            rdata_q   <= 32'b0;
            cnt       <= '0;
            funct3_q  <= 3'b0;
            addr_lo_q <= 2'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        BUS_REQ   <= 1'b1;
                        BUS_WE    <= is_store;
                        BUS_ADDR  <= {IM_ADDR[ADDR_W-1:2], 2'b00};
                        BUS_BE    <= be;
                        BUS_WDATA <= wdata_lanes;
                        funct3_q  <= IM_FUNCT3;
                        addr_lo_q <= IM_ADDR[1:0];
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (BUS_ACK) begin
                        BUS_REQ <= 1'b0;
                        BUS_WE  <= 1'b0;
                        rdata_q <= BUS_WE ? 32'b0 : rdata_ext;
                    end else if (timed_out) begin
                        BUS_REQ <= 1'b0;
                        BUS_WE  <= 1'b0;
                        rdata_q <= 32'b0;
                        BUS_ERR <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    BUS_ERR <= 1'b0;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized accesses against an arithmetic reference model.
module tb_dmem_ctrl;
    import riscv_mem_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] bus_rd;
        int          wait_n;
        int          exp_stall;
        int          exp_reqs;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic        exp_we;
        logic        exp_mis;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          stall;
        int          reqs;
        logic        done;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        we;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_memread, im_memwrite;
    logic [2:0]  im_funct3;
    logic [31:0] im_addr, im_wdata;
    logic        mem_rdy;
    logic [31:0] im_rdata;
    logic        misaligned, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    dmem_state_t dbg_state;

    int errors = 0;
    int checks = 0;
    int txn_cnt = 0;
    logic prev_req = 1'b0;
    logic [31:0] exp_q[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .CLK(clk), .RST(rst),
        .IM_MEMREAD(im_memread), .IM_MEMWRITE(im_memwrite), .IM_FUNCT3(im_funct3),
        .IM_ADDR(im_addr), .IM_WDATA(im_wdata),
        .MEM_RDY(mem_rdy), .IM_RDATA(im_rdata), .MISALIGNED(misaligned), .BUS_ERR(bus_err),
        .BUS_REQ(bus_req), .BUS_WE(bus_we), .BUS_ADDR(bus_addr), .BUS_BE(bus_be),
        .BUS_WDATA(bus_wdata), .BUS_ACK(bus_ack), .BUS_RDATA(bus_rdata),
        .DBG_STATE(dbg_state)
    );

    // Counts distinct bus transactions by rising edges of the request line.
    always @(negedge clk) begin
        if (bus_req && !prev_req) txn_cnt <= txn_cnt + 1;
        prev_req <= bus_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        im_memread  = 1'b0;
        im_memwrite = 1'b0;
        im_funct3   = 3'b000;
        im_addr     = 32'h0;
        im_wdata    = 32'h0;
    endtask

    // Reference model: size/offset arithmetic straight from the access rules.
    function automatic vec_t make_vec(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [31:0] word, input int wait_n);
        vec_t v;
        int size, off;
        bit sgn;
        longint field;
        longint unsigned w64;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.bus_rd = word; v.wait_n = wait_n;
        size = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        sgn  = (f3 == 3'b000 || f3 == 3'b001);
        off  = int'(addr % 4);
        v.exp_mis    = (int'(addr % 32'(size)) != 0);
        v.exp_be     = 4'(((1 << size) - 1) << off);
        v.exp_baddr  = addr - 32'(off);
        v.exp_bwdata = (size == 1) ? wd[7:0] * 32'h01010101 :
                       (size == 2) ? wd[15:0] * 32'h00010001 : wd;
        v.exp_we     = wr;
        w64   = 64'(word);
        field = longint'((w64 >> (8 * off)) & ((64'd1 << (8 * size)) - 1));
        if (sgn && field >= (longint'(1) << (8 * size - 1))) field = field - (longint'(1) << (8 * size));
        v.exp_rdata = wr ? 32'h0 : 32'(field);
        v.exp_err   = 1'b0;
        if (v.exp_mis) begin
            v.exp_stall = 0; v.exp_reqs = 0; v.exp_rdata = 32'h0;
        end else if (wait_n >= TO) begin
            v.exp_stall = TO + 1; v.exp_reqs = TO; v.exp_rdata = 32'h0; v.exp_err = 1'b1;
        end else begin
            v.exp_stall = wait_n + 2; v.exp_reqs = wait_n + 1;
        end
        return v;
    endfunction

    // Drives one instruction and acts as the bus slave until MEM_RDY; returns
    // just after the edge at which the pipeline advances.
    task automatic run_access(input vec_t v, output res_t r);
        r = '{default: '0};
        im_memread = v.rd; im_memwrite = v.wr; im_funct3 = v.f3;
        im_addr = v.addr; im_wdata = v.wd; bus_rdata = v.bus_rd;
        #1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus_req) begin
                r.reqs++;
                r.be = bus_be; r.baddr = bus_addr; r.bwdata = bus_wdata; r.we = bus_we;
                bus_ack = (r.reqs == v.wait_n + 1);
            end else begin
                bus_ack = 1'b0;
            end
            if (mem_rdy) begin
                r.done = 1'b1; r.rdata = im_rdata; r.err = bus_err; r.mis = misaligned;
                break;
            end
            r.stall++;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_res(input string tag, input vec_t v, input res_t r);
        chk({tag, " done"}, 32'(r.done), 32'd1);
        chk({tag, " stall"}, r.stall, v.exp_stall);
        chk({tag, " reqs"}, r.reqs, v.exp_reqs);
        chk({tag, " rdata"}, r.rdata, v.exp_rdata);
        chk({tag, " err"}, 32'(r.err), 32'(v.exp_err));
        chk({tag, " mis"}, 32'(r.mis), 32'(v.exp_mis));
        if (!v.exp_mis) begin
            chk({tag, " be"}, 32'(r.be), 32'(v.exp_be));
            chk({tag, " baddr"}, r.baddr, v.exp_baddr);
            chk({tag, " bwdata"}, r.bwdata, v.exp_bwdata);
            chk({tag, " we"}, 32'(r.we), 32'(v.exp_we));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, v2;
        res_t r, r2;
        int t0;

        // rd wr f3 addr wd bus_rd wait | stall reqs rdata be baddr bwdata we mis err
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,   2, 1, 32'hDEADBEEF, 4'hF, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,   2, 1, 32'hFFFFFF80, 4'h8, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0,   2, 1, 32'h00000080, 4'h8, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0,   2, 1, 32'h000080FF, 4'hC, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0,        3,   5, 4, 32'h0,        4'h2, 32'h200, 32'h78787878, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0,   0, 0, 32'h0,        4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 32'h0,        0,   0, 0, 32'h0,        4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h11111111, 255, 5, 4, 32'h0,        4'hF, 32'h300, 32'h0,        1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h402, 32'h0,        32'h80FF1234, 1,   3, 2, 32'hFFFF80FF, 4'hC, 32'h400, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'b110, 32'h104, 32'hCAFEF00D, 32'h0,        2,   4, 3, 32'h0,        4'hF, 32'h104, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h0000BEEF, 32'h0,        0,   2, 1, 32'h0,        4'hC, 32'h204, 32'hBEEFBEEF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'b010, 32'h010, 32'h5A5A5A5A, 32'hFFFFFFFF, 0,   2, 1, 32'h0,        4'hF, 32'h010, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0,   2, 1, 32'h0000007F, 4'h2, 32'h000, 32'h0,        1'b0, 1'b0, 1'b0};

        // Clock/reset
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst state", 32'(dbg_state), 32'(IDLE));
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_be", 32'(bus_be), 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst im_rdata", im_rdata, 32'h0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst mem_rdy", 32'(mem_rdy), 32'd1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            t0 = txn_cnt;
            run_access(tbl[i], r);
            set_idle();
            check_res($sformatf("vec%0d", i), tbl[i], r);
            chk($sformatf("vec%0d txns", i), txn_cnt - t0, (tbl[i].exp_mis ? 0 : 1));
            chk($sformatf("vec%0d idle", i), 32'(dbg_state), 32'(IDLE));
            chk($sformatf("vec%0d req_low", i), 32'(bus_req), 32'd0);
            @(posedge clk); #1;
        end

        // ACK while idle is ignored
        bus_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stray ack state", 32'(dbg_state), 32'(IDLE));
        chk("stray ack req", 32'(bus_req), 32'd0);
        chk("stray ack rdy", 32'(mem_rdy), 32'd1);
        bus_ack = 1'b0;
        @(posedge clk); #1;

        // Back-to-back LW then SW with no idle gap
        v  = make_vec(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 0);
        v2 = make_vec(1'b0, 1'b1, 3'b010, 32'h604, 32'h76543210, 32'h0, 0);
        t0 = txn_cnt;
        run_access(v, r);
        run_access(v2, r2);
        set_idle();
        check_res("b2b lw", v, r);
        check_res("b2b sw", v2, r2);
        chk("b2b txns", txn_cnt - t0, 2);
        @(posedge clk); #1;

        // Reset in the 2nd REQ cycle drops the access
        im_memread = 1'b1; im_memwrite = 1'b0; im_funct3 = 3'b010;
        im_addr = 32'h500; bus_rdata = 32'h2468ACE0;
        @(posedge clk); #1;
        chk("rst mid req1", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        chk("rst mid req2", 32'(bus_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        chk("rst mid bus_req", 32'(bus_req), 32'd0);
        chk("rst mid state", 32'(dbg_state), 32'(IDLE));
        chk("rst mid rdata", im_rdata, 32'h0);
        @(posedge clk); #1;
        v = make_vec(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h13579BDF, 1);
        run_access(v, r);
        set_idle();
        check_res("post rst lw", v, r);
        @(posedge clk); #1;

        // Randomized accesses with an expected-data queue
        for (int i = 0; i < 40; i++) begin
            int sel, w;
            sel = $urandom_range(1, 3);
            w   = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
            v = make_vec(sel[0], sel[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, w);
            exp_q.push_back(v.exp_rdata);
            run_access(v, r);
            set_idle();
            check_res($sformatf("rnd%0d", i), v, r);
            chk($sformatf("rnd%0d sb", i), r.rdata, exp_q.pop_front());
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
